// File: rtl/dmem_responder.sv
// Data-memory responder: one byte/half/word load or store at a time over valid/ready
// channels, with wait states, range/alignment/funct3 checking and little-endian lanes.
module dmem_responder #(
   parameter int DEPTH_WORDS = 64,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_error
);
   localparam int          AW        = $clog2(DEPTH_WORDS);
   localparam logic [31:0] MAX_ADDR  = 32'(DEPTH_WORDS * 4 - 1);
   localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]  state;
   logic [3:0]  wait_cnt;
   logic        lat_write;
   logic [31:0] lat_addr;
   logic [2:0]  lat_funct3;
   logic [31:0] lat_wdata;
   logic [31:0] mem [DEPTH_WORDS];

   logic        accept;
   logic        go_resp;
   logic        cur_write;
   logic [31:0] cur_addr;
   logic [2:0]  cur_funct3;
   logic [31:0] cur_wdata;
   logic [AW-1:0] idx;
   logic [1:0]  off;
   logic [31:0] word;
   logic [31:0] shifted;
   logic        illegal;
   logic        misalign;
   logic        err;
   logic [31:0] load_val;
   logic [31:0] store_data;
   logic [3:0]  byte_en;

   assign req_ready = (state == S_IDLE);
   assign rsp_valid = (state == S_RESP);
   assign accept    = req_valid & req_ready;
   assign go_resp   = (WAIT_CYCLES == 0) ? accept : ((state == S_WAIT) && (wait_cnt == 4'd1));

   // With no wait states the response is formed on the accepting edge, so decode the live request.
   assign cur_write  = req_ready ? req_write  : lat_write;
   assign cur_addr   = req_ready ? req_addr   : lat_addr;
   assign cur_funct3 = req_ready ? req_funct3 : lat_funct3;
   assign cur_wdata  = req_ready ? req_wdata  : lat_wdata;

   assign idx     = cur_addr[AW+1:2];
   assign off     = cur_addr[1:0];
   assign word    = mem[idx];
   assign shifted = word >> {off, 3'b000};

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      illegal    = 1'b0;
      misalign   = 1'b0;
      load_val   = word;
      store_data = cur_wdata;
      byte_en    = 4'b1111;

      if (cur_write) illegal = cur_funct3[2] | (cur_funct3[1:0] == 2'b11);
      else           illegal = (cur_funct3[1:0] == 2'b11) | (cur_funct3 == 3'b110);

      misalign = ((cur_funct3[1:0] == 2'b01) & off[0]) |
                 ((cur_funct3[1:0] == 2'b10) & (off != 2'b00));

      case (cur_funct3)
         3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
         3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
         3'b100:  load_val = {24'd0, shifted[7:0]};
         3'b101:  load_val = {16'd0, shifted[15:0]};
         default: load_val = word;
      endcase

      case (cur_funct3[1:0])
         2'b00: begin
            store_data = {4{cur_wdata[7:0]}};
            byte_en    = 4'b0001 << off;
         end
         2'b01: begin
            store_data = {2{cur_wdata[15:0]}};
            byte_en    = off[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            store_data = cur_wdata;
            byte_en    = 4'b1111;
         end
      endcase
   end

   assign err = (cur_addr > MAX_ADDR) | illegal | misalign;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         wait_cnt   <= 4'd0;
         lat_write  <= 1'b0;
         lat_addr   <= 32'd0;
         lat_funct3 <= 3'd0;
         lat_wdata  <= 32'd0;
         rsp_rdata  <= 32'd0;
         rsp_error  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (accept) begin
               lat_write  <= req_write;
               lat_addr   <= req_addr;
               lat_funct3 <= req_funct3;
               lat_wdata  <= req_wdata;
               wait_cnt   <= WAIT_INIT;
               state      <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
            end
            S_WAIT: begin
               wait_cnt <= wait_cnt - 4'd1;
               if (wait_cnt == 4'd1) state <= S_RESP;
            end
            S_RESP: if (rsp_ready) state <= S_IDLE;
            default: state <= S_IDLE;
         endcase

         if (go_resp) begin
            rsp_error <= err;
            rsp_rdata <= (err | cur_write) ? 32'd0 : load_val;
         end
      end
   end

   // NOTE: the data array has no reset; contents survive reset and a reset would block RAM inference.
   always_ff @(posedge clk) begin
      if (go_resp && !reset && cur_write && !err) begin
         for (int b = 0; b < 4; b++) begin
            if (byte_en[b]) mem[idx][b*8 +: 8] <= store_data[b*8 +: 8];
         end
      end
   end
endmodule
